pio_input_capture: RTL and testbench
====================================

PIO_INPUT_CAPTURE -- requirements
Module: pio_input_capture

Interface
REQ-001 Parameter WIDTH, default 8, input port width, legal 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, edge selection: 0 rising, 1 falling, 2 any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0, stability cycles before accepting an input change; 0 bypasses debounce; legal 0..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  registered read data, zero-extended.
REQ-012 irq  output  1  level interrupt, active high.

Function
REQ-013 Register map SHALL be: 0 data (RO), 1 reserved (reads 0, writes ignored), 2 irqmask (RW, WIDTH bits), 3 edgecapture (read; write-1-to-clear).
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer (sync1, sync2).
REQ-015 With DEBOUNCE_CYCLES=0, the filtered value d SHALL equal sync2, with no extra register.
REQ-016 With DEBOUNCE_CYCLES>0, each bit SHALL run a counter:
- cleared while sync2==d;
- incremented while sync2!=d;
- when it reaches DEBOUNCE_CYCLES-1 while sync2!=d, d<=sync2 and the counter clears.
REQ-017 Any return of sync2 to d SHALL clear the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
REQ-018 A register prev SHALL hold d delayed by one cycle.
REQ-019 Edge detection per bit:
- rising = d & ~prev;
- falling = ~d & prev;
- any = d ^ prev;
- selected by EDGE_TYPE.
REQ-020 A detected edge SHALL set the corresponding edgecapture bit on the next clock edge; set bits hold until cleared.
REQ-021 A write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1.
REQ-022 When an edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-023 A write to address 2 SHALL load irqmask <= writedata[WIDTH-1:0].
REQ-024 irq SHALL equal |(edgecapture & irqmask), combinational from registers, with no added latency.
REQ-025 Reads:
- readdata is updated every cycle (no read strobe) with the mux output selected by address;
- the read value is valid one cycle after address is presented;
- bits 31:WIDTH read 0.
REQ-026 Latency with debounce bypassed: in_port sampled at edge N -> d visible at edge N+1 -> edgecapture/irq set at edge N+2.
REQ-027 Latency with debounce: in_port sampled at edge N -> d updates at edge N+DEBOUNCE_CYCLES+1 -> edgecapture set one edge later.
REQ-028 Writes to addresses 0 and 1 SHALL have no effect.

Reset
REQ-029 On reset_n=0 (asynchronous) the following SHALL clear to 0: sync1, sync2, d, prev, debounce counters, irqmask, edgecapture, readdata.
REQ-030 irq SHALL be 0 during reset.
REQ-031 An input held high through reset SHALL produce one rising edge (and one "any" edge) after release; this is required behaviour.
REQ-032 Reset asserted mid-debounce SHALL discard the pending count.

Structure
REQ-033 A shared package pio_pkg SHALL hold:
- register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3);
- edge-type constants (EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2).
REQ-034 Sub-module pio_debounce_bit SHALL implement the per-bit synchronizer, debounce counter and d output, instantiated WIDTH times via generate.
REQ-035 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), minimum 1.

Verification
REQ-036 WIDTH=8, EDGE_TYPE=0, DEBOUNCE=0:
- stimulus: in_port 0x00->0x05 at edge N;
- response: edgecapture=0x05 at edge N+2, irq=0 (mask 0);
- then write irqmask=0x04 -> irq=1 next cycle.
REQ-037 Write-1-to-clear:
- stimulus: edgecapture=0x05, write 0x04 to address 3;
- response: edgecapture=0x01; irq drops with mask 0x04;
- then write 0x01 -> 0x00.
REQ-038 Set-wins collision: a bit-0 rising edge coincides with a clear write of 0x01 -> edgecapture[0] stays 1.
REQ-039 DEBOUNCE=4:
- a 3-cycle high pulse on in_port[0] -> d stays 0, no capture;
- a 10-cycle high level -> d=1 at edge N+5, edgecapture[0]=1 at N+6.
REQ-040 Mode and reset checks:
- EDGE_TYPE=2: toggling in_port[3] 1->0 sets edgecapture[3];
- readdata from address 1 = 0;
- reset_n low mid-operation with edgecapture=0xFF, irqmask=0xFF -> all cleared, irq=0 immediately;
- in_port=0x80 held through reset -> edgecapture=0x80 after release (EDGE_TYPE=0).

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the PIO input-capture block.
// Holds the Avalon-MM register word addresses, the edge-type selector values
// and a helper that sizes the per-bit debounce counter.
package pio_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge-type selector values
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Counter width able to hold DEBOUNCE_CYCLES, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer followed by an optional stability filter.
//
// Ports:
//   clk      - clock, all state on rising edge
//   reset_n  - asynchronous active-low reset
//   in_bit   - asynchronous external input
//   d        - synchronized (and, if enabled, debounced) value
//
// With DEBOUNCE_CYCLES = 0 the output is the second synchronizer flop directly.
// Otherwise d only follows sync2 after sync2 has differed from d for
// DEBOUNCE_CYCLES consecutive cycles; any return to d restarts the count.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic d
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_bit;
      sync2_q <= sync1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign d = sync2_q;
  end else begin : g_filter
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            d_q, d_d;

    always_comb begin
      cnt_d = cnt_q;
      d_d   = d_q;
      if (sync2_q == d_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        // Input has been stable at the new value long enough: accept it.
        d_d   = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        d_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        d_q   <= d_d;
      end
    end

    assign d = d_q;
  end

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM parallel input port with edge capture and level interrupt.
//
// Ports:
//   clk         - clock, all state on rising edge
//   reset_n     - asynchronous active-low reset
//   address     - register word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  - slave select
//   write_n     - active-low write strobe (write = chipselect & ~write_n)
//   writedata   - write data
//   in_port     - asynchronous external inputs
//   readdata    - registered read data, zero-extended, valid one cycle after address
//   irq         - level interrupt, |(edgecapture & irqmask)
module pio_input_capture
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      readdata_d;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are ever stored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .d       (d[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    if (EDGE_TYPE == EDGE_FALL) begin
      edges = ~d & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edges = d ^ prev_q;
    end else begin
      edges = d & ~prev_q;
    end
  end

  always_comb begin
    clr_mask  = '0;
    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr_mask = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // OR-ing edges after the clear makes a same-cycle set win.
    edgecap_d = (edgecap_q & ~clr_mask) | edges;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(d);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      readdata  <= '0;
    end else begin
      prev_q    <= d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      readdata  <= readdata_d;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_input_capture.sv
// Directed bench for pio_input_capture. Three instances share one clock:
//   0: WIDTH 8, rising edge, no debounce
//   1: WIDTH 8, rising edge, DEBOUNCE_CYCLES 4
//   2: WIDTH 8, any edge, no debounce
module tb_pio_input_capture;

  logic             clk;
  logic             reset_n;
  logic [2:0][1:0]  addr;
  logic [2:0]       cs;
  logic [2:0]       wn;
  logic [2:0][31:0] wd;
  logic [2:0][7:0]  pin;
  logic [2:0][31:0] rdata;
  logic [2:0]       irq_v;

  int checks;
  int failures;

  pio_input_capture #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
    .writedata(wd[0]), .in_port(pin[0]), .readdata(rdata[0]), .irq(irq_v[0])
  );

  pio_input_capture #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
    .writedata(wd[1]), .in_port(pin[1]), .readdata(rdata[1]), .irq(irq_v[1])
  );

  pio_input_capture #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .address(addr[2]), .chipselect(cs[2]), .write_n(wn[2]),
    .writedata(wd[2]), .in_port(pin[2]), .readdata(rdata[2]), .irq(irq_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int k, input logic [1:0] a, input logic [31:0] v);
    addr[k] = a;
    wd[k]   = v;
    cs[k]   = 1'b1;
    wn[k]   = 1'b0;
    tick();
    cs[k]   = 1'b0;
    wn[k]   = 1'b1;
    wd[k]   = '0;
  endtask

  task automatic rd(input int k, input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr[k] = a;
    tick();
    chk(tag, rdata[k], exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    addr     = '0;
    cs       = '0;
    wn       = '1;
    wd       = '0;
    pin      = '0;

    repeat (3) tick();
    chk("reset_irq", {29'b0, irq_v}, 32'h0);
    chk("reset_rdata_a", rdata[0], 32'h0);
    reset_n = 1'b1;
    tick();
    rd(0, 2'd3, 32'h0, "a_edgecap_after_reset");
    rd(0, 2'd2, 32'h0, "a_irqmask_after_reset");

    // ---- Instance A: rising edge, no debounce ----
    addr[0] = 2'd3;
    pin[0]  = 8'h05;
    tick();                                 // edge N: sync1
    tick();                                 // edge N+1: d
    tick();                                 // edge N+2: edgecapture set
    chk("a_rd_before_capture", rdata[0], 32'h0);
    chk("a_irq_mask0", {31'b0, irq_v[0]}, 32'h0);
    tick();
    chk("a_edgecap_05", rdata[0], 32'h05);
    wr(0, 2'd2, 32'h04);
    chk("a_irq_after_mask", {31'b0, irq_v[0]}, 32'h1);
    rd(0, 2'd2, 32'h04, "a_irqmask_rd");
    rd(0, 2'd0, 32'h05, "a_data_rd");

    // Write-1-to-clear
    wr(0, 2'd3, 32'h04);
    chk("a_irq_after_clr", {31'b0, irq_v[0]}, 32'h0);
    rd(0, 2'd3, 32'h01, "a_edgecap_after_clr4");
    wr(0, 2'd3, 32'h01);
    rd(0, 2'd3, 32'h00, "a_edgecap_after_clr1");

    // Writes to data and reserved are ignored
    wr(0, 2'd0, 32'hFF);
    wr(0, 2'd1, 32'hFF);
    rd(0, 2'd1, 32'h0, "a_rsvd_rd");
    rd(0, 2'd0, 32'h05, "a_data_after_wr0");
    rd(0, 2'd2, 32'h04, "a_irqmask_unchanged");
    rd(0, 2'd3, 32'h00, "a_edgecap_unchanged");

    // Falling edge must not capture in rising mode
    pin[0] = 8'h04;
    repeat (3) tick();
    rd(0, 2'd3, 32'h00, "a_falling_ignored");

    // Set-wins: bit 0 rises at the same edge as a clear of bit 0
    pin[0] = 8'h05;
    tick();                                 // N
    tick();                                 // N+1
    wr(0, 2'd3, 32'h01);                    // write lands on N+2 with the edge
    rd(0, 2'd3, 32'h01, "a_set_wins");
    wr(0, 2'd3, 32'h01);
    rd(0, 2'd3, 32'h00, "a_cleared_again");

    // ---- Instance B: debounce 4 ----
    wr(1, 2'd2, 32'h01);
    addr[1] = 2'd0;
    pin[1]  = 8'h01;                        // 3-cycle glitch
    repeat (3) tick();
    pin[1]  = 8'h00;
    repeat (6) tick();
    chk("b_irq_glitch", {31'b0, irq_v[1]}, 32'h0);
    rd(1, 2'd0, 32'h0, "b_data_glitch");
    rd(1, 2'd3, 32'h0, "b_edgecap_glitch");

    addr[1] = 2'd0;
    pin[1]  = 8'h01;                        // sampled at edge N
    repeat (6) tick();                      // now just after N+5
    chk("b_data_before_n5", rdata[1], 32'h0);
    chk("b_irq_before_n6", {31'b0, irq_v[1]}, 32'h0);
    tick();                                 // just after N+6
    chk("b_data_after_n5", rdata[1], 32'h1);
    chk("b_irq_at_n6", {31'b0, irq_v[1]}, 32'h1);
    repeat (4) tick();

    // ---- Instance C: any edge ----
    pin[2] = 8'h08;
    repeat (3) tick();
    wr(2, 2'd3, 32'h08);
    rd(2, 2'd3, 32'h00, "c_cleared_after_rise");
    pin[2] = 8'h00;
    repeat (3) tick();
    rd(2, 2'd3, 32'h08, "c_fall_captured");
    wr(2, 2'd1, 32'hFFFF_FFFF);
    rd(2, 2'd1, 32'h0, "c_rsvd_rd");

    // ---- Asynchronous reset mid-operation ----
    pin[0] = 8'h00;
    repeat (3) tick();
    pin[0] = 8'hFF;
    repeat (3) tick();
    pin[1] = 8'h00;                         // start a pending debounce count on B
    wr(0, 2'd2, 32'hFF);
    chk("a_irq_full", {31'b0, irq_v[0]}, 32'h1);
    rd(0, 2'd3, 32'hFF, "a_edgecap_full");
    tick();
    addr[1] = 2'd0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    pin[0]  = 8'h80;
    pin[1]  = 8'h01;
    #1;
    chk("a_irq_in_reset", {31'b0, irq_v[0]}, 32'h0);
    chk("a_rdata_in_reset", rdata[0], 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();                      // R1 sync1, R2 d, R3 capture
    rd(0, 2'd3, 32'h80, "a_held_through_reset");
    rd(0, 2'd2, 32'h00, "a_irqmask_after_reset2");
    tick();                                 // after R6: readdata holds d before R6
    chk("b_data_before_r6", rdata[1], 32'h0);
    tick();
    chk("b_data_after_r6", rdata[1], 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
